// File: rtl/reduce_gate_pipe.sv
// Pipelined 4-ary reduction gate (OR/AND/XOR) with input bubbles and output invert.
// Optional sticky "Result was 1" flag built when REDUCE_GATE_STICKY_EN is defined.
module reduce_gate_pipe #(
    parameter int                INPUTS       = 21,
    parameter int                MODE         = 0,
    parameter logic [INPUTS-1:0] BubblesMask  = '0,
    parameter bit                OutputInvert = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ClockEnable,
    input  logic              In_Valid,
    input  logic [INPUTS-1:0] Inputs,
    input  logic              Clear,
    output logic              Result,
    output logic              Out_Valid,
    output logic              Sticky
);

    // Width of the operand vector after j tree levels.
    function automatic int lvl_w(input int n, input int j);
        int w;
        w = n;
        for (int i = 0; i < j; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

    // Number of tree levels, never fewer than one.
    function automatic int num_lvls(input int n);
        int w;
        int l;
        w = n;
        l = 0;
        while (w > 1) begin
            w = (w + 3) / 4;
            l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    // One 4-input group of the selected operator.
    function automatic logic red4(input logic [3:0] v);
        if (MODE == 1) begin
            return &v;
        end else if (MODE == 2) begin
            return ^v;
        end
        return |v;
    endfunction

    localparam int   L     = num_lvls(INPUTS);
    localparam logic IDENT = (MODE == 1);

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int WI = lvl_w(INPUTS, j);
        localparam int WO = lvl_w(INPUTS, j + 1);

        logic [WI-1:0]   w_in;
        logic            w_vin;
        logic [4*WO-1:0] w_pad;
        logic [WO-1:0]   w_red;
        logic [WO-1:0]   r_data;
        logic            r_vld;

        if (j == 0) begin : g_src
            assign w_in  = Inputs ^ BubblesMask;
            assign w_vin = In_Valid;
        end else begin : g_src
            assign w_in  = g_lvl[j-1].r_data;
            assign w_vin = g_lvl[j-1].r_vld;
        end

        // Pad the short last group with the operator identity, reduce in fours.
        always_comb begin
            w_pad = {(4*WO){IDENT}};
            w_pad[WI-1:0] = w_in;
            w_red = '0;
            for (int g = 0; g < WO; g++) begin
                w_red[g] = red4(w_pad[4*g +: 4]);
            end
            if (j == L - 1) begin
                w_red = w_red ^ {WO{OutputInvert}};
            end
        end

        // Level register with its valid bit; frozen when the pipe is stalled.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_data <= '0;
                r_vld  <= 1'b0;
            end else if (ClockEnable) begin
                r_data <= w_red;
                r_vld  <= w_vin;
            end
        end
    end

    assign Result    = g_lvl[L-1].r_data[0];
    assign Out_Valid = g_lvl[L-1].r_vld;

`ifdef REDUCE_GATE_STICKY_EN
    logic r_sticky;

    // Latch any valid 1 on Result; a set event wins over Clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sticky <= 1'b0;
        end else if (ClockEnable) begin
            if (Out_Valid && Result) begin
                r_sticky <= 1'b1;
            end else if (Clear) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign Sticky = r_sticky;
`else
    logic w_unused_clear;

    assign w_unused_clear = Clear;
    assign Sticky         = 1'b0;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Bench for reduce_gate_pipe: three configurations driven in lockstep,
// table vectors, directed stall/reset/sticky sequences and random traffic.
module tb_reduce_gate_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce;
    logic        vin;
    logic        clr;
    logic [20:0] x;
    logic [4:0]  x5;
    logic [2:0]  res;
    logic [2:0]  ov;
    logic [2:0]  st;

    assign x5 = x[4:0];

    reduce_gate_pipe #(
        .INPUTS(21), .MODE(0), .BubblesMask(21'h0), .OutputInvert(1'b0)
    ) u_or (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .In_Valid(vin),
        .Inputs(x), .Clear(clr),
        .Result(res[0]), .Out_Valid(ov[0]), .Sticky(st[0])
    );

    reduce_gate_pipe #(
        .INPUTS(21), .MODE(1), .BubblesMask(21'h000001), .OutputInvert(1'b1)
    ) u_nand (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .In_Valid(vin),
        .Inputs(x), .Clear(clr),
        .Result(res[1]), .Out_Valid(ov[1]), .Sticky(st[1])
    );

    reduce_gate_pipe #(
        .INPUTS(5), .MODE(2), .BubblesMask(5'h0), .OutputInvert(1'b0)
    ) u_xor (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .In_Valid(vin),
        .Inputs(x5), .Clear(clr),
        .Result(res[2]), .Out_Valid(ov[2]), .Sticky(st[2])
    );

    typedef struct {
        logic       v;
        logic [2:0] r;
        int         tag;
    } ent_t;

    typedef struct {
        logic [20:0] x;
        logic [2:0]  e;
    } vec_t;

    ent_t       h[$];
    vec_t       tbl[7];
    logic [2:0] cur_v;
    logic [2:0] cur_r;
    logic [2:0] exp_st;
    int         cur_tag[3];
    int         checks;
    int         errors;

    function automatic int lat(input int i);
        return (i == 2) ? 2 : 3;
    endfunction

    // Reference value from the operator definition: count of ones after bubbling.
    function automatic logic ref_red(input int i, input logic [20:0] val);
        int          n;
        int          cnt;
        logic [20:0] m;
        n   = (i == 2) ? 5 : 21;
        m   = (i == 1) ? 21'h000001 : 21'h0;
        cnt = 0;
        for (int b = 0; b < n; b++) begin
            cnt += int'(val[b] ^ m[b]);
        end
        if (i == 0) return cnt > 0;
        if (i == 1) return !(cnt == n);
        return (cnt % 2) == 1;
    endfunction

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0b want %0b at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        ent_t e;
        e.v = 1'b0;
        e.r = '0;
        e.tag = -1;
        h.delete();
        h.push_back(e);
        h.push_back(e);
        cur_v  = '0;
        cur_r  = '0;
        exp_st = '0;
        for (int i = 0; i < 3; i++) cur_tag[i] = -1;
    endtask

    task automatic step(input logic v, input logic [20:0] xi, input logic c,
                        input logic r, input logic cl, input int tag);
        ent_t e;
        vin = v;
        x   = xi;
        ce  = c;
        rst = r;
        clr = cl;
        @(posedge clk);
        if (r) begin
            reset_model();
        end else if (c) begin
`ifdef REDUCE_GATE_STICKY_EN
            for (int i = 0; i < 3; i++) begin
                if (cur_v[i] && cur_r[i]) exp_st[i] = 1'b1;
                else if (cl) exp_st[i] = 1'b0;
            end
`endif
            e.v   = v;
            e.tag = tag;
            for (int i = 0; i < 3; i++) e.r[i] = ref_red(i, xi);
            h.push_back(e);
            for (int i = 0; i < 3; i++) begin
                e          = h[h.size() - lat(i)];
                cur_v[i]   = e.v;
                cur_r[i]   = e.r[i];
                cur_tag[i] = e.v ? e.tag : -1;
            end
            while (h.size() > 4) void'(h.pop_front());
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("out_valid", i, ov[i], cur_v[i]);
            if (cur_v[i]) chk("result", i, res[i], cur_r[i]);
            if (cur_tag[i] >= 0) chk("tbl", i, res[i], tbl[cur_tag[i]].e[i]);
            if (r) chk("rst_result", i, res[i], 1'b0);
            chk("sticky", i, st[i], exp_st[i]);
        end
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 21'h0, 1'b1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ce  = 1'b0;
        vin = 1'b0;
        clr = 1'b0;
        x   = '0;
        reset_model();

        tbl[0] = '{21'h000000, 3'b010};
        tbl[1] = '{21'h100000, 3'b011};
        tbl[2] = '{21'h1FFFFE, 3'b001};
        tbl[3] = '{21'h1FFFFF, 3'b111};
        tbl[4] = '{21'h000001, 3'b111};
        tbl[5] = '{21'h000003, 3'b011};
        tbl[6] = '{21'h000017, 3'b011};

        step(1'b0, 21'h0, 1'b1, 1'b1, 1'b0, -1);
        step(1'b1, 21'h1FFFFF, 1'b0, 1'b1, 1'b0, -1);

        for (int k = 0; k < 7; k++) step(1'b1, tbl[k].x, 1'b1, 1'b0, 1'b0, k);
        flush(3);

        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                for (int s = 0; s < 4; s++)
                    step(1'b1, 21'($urandom), 1'b0, 1'b0, 1'b0, -1);
            end
            step(1'b1, 21'($urandom), 1'b1, 1'b0, 1'b0, -1);
        end
        flush(3);

        step(1'b0, 21'h0, 1'b1, 1'b0, 1'b1, -1);
        step(1'b1, 21'h100000, 1'b1, 1'b0, 1'b0, -1);
        flush(2);
        step(1'b0, 21'h0, 1'b1, 1'b0, 1'b1, -1);
        step(1'b0, 21'h0, 1'b1, 1'b0, 1'b1, -1);

        step(1'b1, 21'h1FFFFF, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 21'h000001, 1'b1, 1'b0, 1'b0, -1);
        step(1'b0, 21'h0, 1'b1, 1'b1, 1'b0, -1);
        for (int k = 0; k < 4; k++) step(1'b1, 21'($urandom), 1'b1, 1'b0, 1'b0, -1);
        flush(3);

        for (int k = 0; k < 400; k++) begin
            step(1'($urandom % 2), 21'($urandom), ($urandom % 10) != 0,
                 ($urandom % 50) == 0, ($urandom % 8) == 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
